// File: rtl/iram_port_arb_pkg.sv
// Shared types and defaults for the instruction-RAM port-B arbiter (iram_port_arb).
package iram_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

  localparam int ARB_NM       = 3;
  localparam int ARB_AW       = 14;
  localparam int ARB_MAX_HOLD = 16;
  localparam int DBG_IDX      = ARB_NM - 1;

  // Circular successor of a requester index.
  function automatic int next_idx(input int idx, input int nm);
    return (idx + 1 >= nm) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/iram_port_arb_if.sv
// Requester bus and BRAM port-B signals of the instruction-RAM arbiter.
// Handshake: a requester holds m_req (and its we/addr/wdata/wem) until it sees m_gnt in the
// same cycle; the access happens on that cycle, and a read returns with m_rvalid one cycle later.
interface iram_port_arb_if #(
  parameter int NM = 3,
  parameter int AW = 14
) ();
  logic [NM-1:0]    m_req;
  logic [NM-1:0]    m_we;
  logic [NM*AW-1:0] m_addr;
  logic [NM*32-1:0] m_wdata;
  logic [NM*4-1:0]  m_wem;
  logic [NM-1:0]    m_gnt;
  logic [NM-1:0]    m_rvalid;
  logic [31:0]      m_rdata;
  logic             ram_en;
  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [31:0]      ram_wdata;
  logic [3:0]       ram_wem;
  logic [31:0]      ram_rdata;

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, m_wem, ram_rdata,
    output m_gnt, m_rvalid, m_rdata, ram_en, ram_we, ram_addr, ram_wdata, ram_wem
  );

  modport master (
    output m_req, m_we, m_addr, m_wdata, m_wem, ram_rdata,
    input  m_gnt, m_rvalid, m_rdata, ram_en, ram_we, ram_addr, ram_wdata, ram_wem
  );
endinterface

// File: rtl/iram_port_arb_rr_pick.sv
// Combinational circular-priority picker: first eligible requester at or after i_ptr.
module rr_pick #(
  parameter int NM = 3,
  parameter int PW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic [NM-1:0] i_req,
  input  logic [NM-1:0] i_excl,
  input  logic [PW-1:0] i_ptr,
  output logic [NM-1:0] o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);
  logic [NM-1:0] w_elig;

  assign w_elig = i_req & ~i_excl;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 0; k < NM; k++) begin
      if (!o_any && w_elig[(int'(i_ptr) + k) % NM]) begin
        o_any = 1'b1;
        o_gnt[(int'(i_ptr) + k) % NM] = 1'b1;
        o_idx = PW'((int'(i_ptr) + k) % NM);
      end
    end
  end
endmodule

// File: rtl/iram_port_arb.sv
// Round-robin arbiter for port B of the instruction RAM, bounded ownership, zero-bubble handover.
// Optional build macro IRAM_ARB_DBG_PRIO_EN: requester NM-1 (debug) preempts everyone.
module iram_port_arb
  import iram_arb_pkg::*;
#(
  parameter int NM       = ARB_NM,
  parameter int AW       = ARB_AW,
  parameter int MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic               clk,
  input  logic               rst_n,
  iram_port_arb_if.slave     bus,
  output arb_state_e         o_dbg_state
);
  localparam int PW    = (NM > 1) ? $clog2(NM) : 1;
  localparam int HW    = $clog2(MAX_HOLD + 1);
  localparam int DBG_M = NM - 1;

  arb_state_e    r_state, w_nxt_state;
  logic [PW-1:0] r_owner, w_nxt_owner;
  logic [PW-1:0] r_ptr, w_nxt_ptr;
  logic [HW-1:0] r_hold, w_nxt_hold;
  logic [NM-1:0] r_rvalid;

  logic [NM-1:0] w_owner_oh, w_excl, w_pick_gnt, w_gnt;
  logic [PW-1:0] w_pick_idx, w_sel;
  logic          w_pick_any, w_owner_req;

  always_comb begin
    w_owner_oh = '0;
    for (int i = 0; i < NM; i++) w_owner_oh[i] = (r_owner == PW'(i));
  end

  // While busy the owner is masked out, so w_pick_any means "some other master is requesting".
  assign w_excl      = (r_state == ARB_BUSY) ? w_owner_oh : '0;
  assign w_owner_req = |(bus.m_req & w_owner_oh);

  rr_pick #(.NM(NM), .PW(PW)) u_pick (
    .i_req  (bus.m_req),
    .i_excl (w_excl),
    .i_ptr  (r_ptr),
    .o_gnt  (w_pick_gnt),
    .o_idx  (w_pick_idx),
    .o_any  (w_pick_any)
  );

  always_comb begin
    w_gnt       = '0;
    w_sel       = r_owner;
    w_nxt_state = r_state;
    w_nxt_owner = r_owner;
    w_nxt_ptr   = r_ptr;
    w_nxt_hold  = r_hold;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_any) begin
          w_gnt       = w_pick_gnt;
          w_sel       = w_pick_idx;
          w_nxt_state = ARB_BUSY;
          w_nxt_owner = w_pick_idx;
          w_nxt_hold  = HW'(1);
          w_nxt_ptr   = PW'(next_idx(int'(w_pick_idx), NM));
        end
      end
      ARB_BUSY: begin
        if (w_owner_req && ((r_hold < HW'(MAX_HOLD)) || !w_pick_any)) begin
          w_gnt = w_owner_oh;
          if (!w_pick_any)                w_nxt_hold = HW'(1);
          else if (r_hold < HW'(MAX_HOLD)) w_nxt_hold = r_hold + HW'(1);
        end else if (w_pick_any) begin
          w_gnt       = w_pick_gnt;
          w_sel       = w_pick_idx;
          w_nxt_owner = w_pick_idx;
          w_nxt_hold  = HW'(1);
          w_nxt_ptr   = PW'(next_idx(int'(w_pick_idx), NM));
        end else begin
          w_nxt_state = ARB_IDLE;
        end
      end
      default: w_nxt_state = ARB_IDLE;
    endcase
`ifdef IRAM_ARB_DBG_PRIO_EN
    // Debug access freezes all arbitration state so round-robin resumes where it left off.
    if (bus.m_req[DBG_M]) begin
      w_gnt        = '0;
      w_gnt[DBG_M] = 1'b1;
      w_sel        = PW'(DBG_M);
      w_nxt_state  = r_state;
      w_nxt_owner  = r_owner;
      w_nxt_ptr    = r_ptr;
      w_nxt_hold   = r_hold;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ARB_IDLE;
      r_owner  <= '0;
      r_ptr    <= '0;
      r_hold   <= '0;
      r_rvalid <= '0;
    end else begin
      r_state  <= w_nxt_state;
      r_owner  <= w_nxt_owner;
      r_ptr    <= w_nxt_ptr;
      r_hold   <= w_nxt_hold;
      r_rvalid <= w_gnt & ~bus.m_we;
    end
  end

  assign bus.m_gnt     = w_gnt;
  assign bus.ram_en    = |w_gnt;
  assign bus.ram_we    = bus.ram_en & bus.m_we[w_sel];
  assign bus.ram_addr  = bus.m_addr[w_sel*AW +: AW];
  assign bus.ram_wdata = bus.m_wdata[w_sel*32 +: 32];
  assign bus.ram_wem   = bus.ram_we ? bus.m_wem[w_sel*4 +: 4] : 4'h0;
  assign bus.m_rvalid  = r_rvalid;
  assign bus.m_rdata   = bus.ram_rdata;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_iram_port_arb.sv
// Directed self-checking bench for iram_port_arb with a write-first 1-cycle BRAM model.
module tb_iram_port_arb;
  import iram_arb_pkg::*;

  localparam int NM = 3;
  localparam int AW = 14;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  arb_state_e dbg_state;
  int         n_chk = 0;
  int         n_pass = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem [0:1023];
  logic [31:0] bram_nv;

  iram_port_arb_if #(.NM(NM), .AW(AW)) bus ();

  iram_port_arb #(.NM(NM), .AW(AW), .MAX_HOLD(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want done");
    $fatal(1);
  end

  // Write-first BRAM model
  always @(posedge clk) begin
    if (bus.ram_en) begin
      bram_nv = mem[bus.ram_addr[9:0]];
      if (bus.ram_we)
        for (int b = 0; b < 4; b++)
          if (bus.ram_wem[b]) bram_nv[8*b +: 8] = bus.ram_wdata[8*b +: 8];
      if (bus.ram_we) mem[bus.ram_addr[9:0]] = bram_nv;
      bus.ram_rdata <= bram_nv;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, act, exp);
  endtask

  // Scoreboard: read return must match the head of the expected queue
  task automatic chk_rd(input string tag, input logic [NM-1:0] rv_exp);
    chk({tag, "_rvalid"}, 32'(bus.m_rvalid), 32'(rv_exp));
    chk({tag, "_q"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) chk({tag, "_rdata"}, bus.m_rdata, exp_q.pop_front());
  endtask

  // Driver
  task automatic set_m(input int i, input logic req, input logic we, input logic [AW-1:0] addr,
                       input logic [31:0] wd, input logic [3:0] wem);
    bus.m_req[i]             = req;
    bus.m_we[i]              = we;
    bus.m_addr[i*AW +: AW]   = addr;
    bus.m_wdata[i*32 +: 32]  = wd;
    bus.m_wem[i*4 +: 4]      = wem;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.m_req   = '0;
    bus.m_we    = '0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.m_wem   = '0;
    bus.ram_rdata = '0;
    for (int a = 0; a < 1024; a++) mem[a] = 32'h0;
    mem[16] = 32'hDEADBEEF;
    mem[5]  = 32'hAABBCCDD;
    mem[32] = 32'h0BADF00D;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(bus.m_gnt), 32'h0);
    chk("rst_rvalid", 32'(bus.m_rvalid), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(ARB_IDLE));
    next_cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("noreq_gnt", 32'(bus.m_gnt), 32'h0);
    chk("noreq_en", 32'(bus.ram_en), 32'h0);

    // Single read by m0
    next_cyc();
    set_m(0, 1'b1, 1'b0, 14'h10, 32'h0, 4'h0);
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    chk("t1_gnt", 32'(bus.m_gnt), 32'h1);
    chk("t1_addr", 32'(bus.ram_addr), 32'h10);
    chk("t1_we", 32'(bus.ram_we), 32'h0);
    next_cyc();
    set_m(0, 1'b0, 1'b0, 14'h10, 32'h0, 4'h0);
    @(negedge clk);
    chk_rd("t1", 3'b001);
    chk("t1_release", 32'(bus.m_gnt), 32'h0);

    // All masters request from reset: 16 grants each, no gaps
    next_cyc();
    rst_n = 1'b0;
    next_cyc();
    rst_n = 1'b1;
    for (int i = 0; i < NM; i++) set_m(i, 1'b1, 1'b0, 14'h10, 32'h0, 4'h0);
    for (int c = 0; c < 49; c++) begin
      @(negedge clk);
      chk($sformatf("t2_gnt_c%0d", c), 32'(bus.m_gnt),
          (c < 16) ? 32'h1 : (c < 32) ? 32'h2 : (c < 48) ? 32'h4 : 32'h1);
      next_cyc();
    end
    for (int i = 0; i < NM; i++) set_m(i, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("t2_idle_gnt", 32'(bus.m_gnt), 32'h0);
    chk("t2_idle_en", 32'(bus.ram_en), 32'h0);

    // Partial-mask write then read-back by m1
    next_cyc();
    set_m(1, 1'b1, 1'b1, 14'h5, 32'h12345678, 4'b0011);
    @(negedge clk);
    chk("t3_wgnt", 32'(bus.m_gnt), 32'h2);
    chk("t3_we", 32'(bus.ram_we), 32'h1);
    chk("t3_wem", 32'(bus.ram_wem), 32'h3);
    chk("t3_wdata", bus.ram_wdata, 32'h12345678);
    next_cyc();
    set_m(1, 1'b1, 1'b0, 14'h5, 32'h0, 4'h0);
    exp_q.push_back(32'hAABB5678);
    @(negedge clk);
    chk("t3_rgnt", 32'(bus.m_gnt), 32'h2);
    chk("t3_rwe", 32'(bus.ram_we), 32'h0);
    next_cyc();
    set_m(1, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk_rd("t3", 3'b010);

    // Read with a full byte mask must not write
    next_cyc();
    set_m(0, 1'b1, 1'b0, 14'h5, 32'hFFFFFFFF, 4'hF);
    exp_q.push_back(32'hAABB5678);
    @(negedge clk);
    chk("t6_gnt", 32'(bus.m_gnt), 32'h1);
    chk("t6_we", 32'(bus.ram_we), 32'h0);
    chk("t6_wem", 32'(bus.ram_wem), 32'h0);
    next_cyc();
    set_m(0, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk_rd("t6", 3'b001);

    // Reset while m2's read is in flight
    next_cyc();
    set_m(2, 1'b1, 1'b0, 14'h10, 32'h0, 4'h0);
    @(negedge clk);
    chk("t4_gnt", 32'(bus.m_gnt), 32'h4);
    rst_n = 1'b0;
    set_m(0, 1'b1, 1'b0, 14'h20, 32'h0, 4'h0);
    next_cyc();
    @(negedge clk);
    chk("t4_rvalid_rst", 32'(bus.m_rvalid), 32'h0);
    next_cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t4_restart_gnt", 32'(bus.m_gnt), 32'h1);
    chk("t4_rvalid_rel", 32'(bus.m_rvalid), 32'h0);

    // m0 owns, then debug master raises its request
    next_cyc();
    set_m(2, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("t5_own_c%0d", c), 32'(bus.m_gnt), 32'h1);
      next_cyc();
    end
    set_m(2, 1'b1, 1'b0, 14'h10, 32'h0, 4'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
`ifdef IRAM_ARB_DBG_PRIO_EN
      chk($sformatf("t5_dbg_c%0d", c), 32'(bus.m_gnt), 32'h4);
`else
      chk($sformatf("t5_dbg_c%0d", c), 32'(bus.m_gnt), 32'h1);
`endif
      next_cyc();
    end
    set_m(2, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("t5_resume", 32'(bus.m_gnt), 32'h1);
    next_cyc();
    set_m(0, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("t5_end_gnt", 32'(bus.m_gnt), 32'h0);
    chk("t5_end_en", 32'(bus.ram_en), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
